// File: rtl/armleo_burst_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared
// valid/ready stream until its last beat completes.
module armleo_burst_arbiter #(
  parameter  int NUM_MASTERS = 4,
  parameter  int DATA_WIDTH  = 32,
  localparam int IDX_W =
    (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_valid,
  output logic [NUM_MASTERS-1:0]           m_ready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data,
  input  logic [NUM_MASTERS-1:0]           m_last,
  output logic                             s_valid,
  input  logic                             s_ready,
  output logic [DATA_WIDTH-1:0]            s_data,
  output logic                             s_last,
  output logic [IDX_W-1:0]                 s_id,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             busy
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] prio_q, prio_d;

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic                     win_vld;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         nxt_prio;
  logic                     locked;
  logic [DATA_WIDTH-1:0]    slice [NUM_MASTERS];

  // Reset gates the outputs so no beat is acked in the reset cycle.
  assign locked   = (state_q == LOCKED) && rst_n;
  assign nxt_prio = IDX_W'((int'(owner_q) + 1) % NUM_MASTERS);

  always_comb begin
    dbl     = {m_valid, m_valid};
    rot     = NUM_MASTERS'(dbl >> prio_q);
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(prio_q) + i) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      slice[k] = m_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (s_valid && s_ready && s_last) begin
          state_d = IDLE;
          prio_d  = nxt_prio;
        end
      end
    endcase
  end

  always_comb begin
    grant   = '0;
    m_ready = '0;
    busy    = 1'b0;
    s_id    = '0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    if (locked) begin
      grant[owner_q]   = 1'b1;
      busy             = 1'b1;
      s_id             = owner_q;
      s_valid          = m_valid[owner_q];
      m_ready[owner_q] = s_ready;
      if (s_valid) begin
        s_data = slice[owner_q];
        s_last = m_last[owner_q];
      end
    end
  end

endmodule

// File: tb/tb_armleo_burst_arbiter.sv
// Bench for armleo_burst_arbiter: vector tables, directed
// burst sequences and a randomized run against a reference model.
module tb_armleo_burst_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  m_valid, m_ready, m_last, grant;
  logic [N*DW-1:0] m_data;
  logic          s_valid, s_ready, s_last, busy;
  logic [DW-1:0] s_data;
  logic [1:0]    s_id;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  armleo_burst_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_id(s_id),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       rdy;
    logic [3:0] gnt;
    logic       sl;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] pat(int k, int b);
    return 32'hC0DE_0000 + 32'(k * 16 + b);
  endfunction

  task automatic setdata(int b);
    for (int k = 0; k < N; k++) m_data[k*DW +: DW] = pat(k, b);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // s_id is only meaningful while a grant is held.
  task automatic expect_out(string nm, logic [3:0] g, logic sv,
                            logic sl, logic [3:0] mr,
                            logic [DW-1:0] sd, logic [1:0] id);
    logic [1:0] aid;
    aid = (g != 0) ? s_id : 2'd0;
    chk(nm, 64'({grant, busy, s_valid, s_last, m_ready, aid, s_data}),
            64'({g, |g, sv, sl, mr, (g != 0) ? id : 2'd0, sd}));
  endtask

  task automatic expect_idle(string nm);
    expect_out(nm, 4'b0, 1'b0, 1'b0, 4'b0, '0, 2'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = '1;
    m_last = '1;
    s_ready = 1'b1;
    setdata(0);
    repeat (2) cyc();
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_ctl", 64'({busy, s_valid, s_last, m_ready, s_id}), 64'(0));
    chk("reset_data", 64'(s_data), 64'(0));
    rst_n = 1'b1;
    m_valid = '0;
    m_last = '0;
  endtask

  task automatic run_tbl(string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      int own;
      logic sv;
      m_valid = tbl[i].vld;
      m_last  = tbl[i].lst;
      s_ready = tbl[i].rdy;
      setdata(0);
      #1;
      own = 0;
      for (int k = 0; k < N; k++) if (tbl[i].gnt[k]) own = k;
      sv = |(tbl[i].gnt & tbl[i].vld);
      expect_out($sformatf("%s[%0d]", nm, i), tbl[i].gnt, sv,
                 tbl[i].sl, tbl[i].rdy ? tbl[i].gnt : 4'b0,
                 sv ? pat(own, 0) : '0, 2'(own));
      cyc();
    end
    tbl.delete();
  endtask

  initial begin
    logic rdys [4];
    int   beat;
    bit   mlock;
    int   mown, mprio;
    logic [3:0] eg, emr;
    logic esv, esl;
    logic [DW-1:0] esd;

    rst_n = 1'b0;
    m_valid = '0; m_last = '0; s_ready = 1'b0; m_data = '0;
    #1;

    // single requester, then the next search starts at 3
    do_reset();
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1});
    run_tbl("single");

    // fairness
    do_reset();
    for (int g = 0; g < 6; g++) begin
      tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
      tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'(1 << (g % 4)), 1'b1});
    end
    run_tbl("fair");

    // lock hold
    do_reset();
    m_valid = 4'b0010; m_last = '0; s_ready = 1'b1; setdata(0);
    #1 expect_idle("lh_arb");
    cyc();
    for (int b = 0; b < 4; b++) begin
      m_valid = 4'b0011;
      m_last = (b == 3) ? 4'b0011 : 4'b0000;
      setdata(b);
      #1 expect_out($sformatf("lh_beat%0d", b), 4'b0010, 1'b1,
                    b == 3, 4'b0010, pat(1, b), 2'd1);
      cyc();
    end
    m_valid = 4'b0001; m_last = 4'b0001;
    #1 expect_idle("lh_bubble");
    cyc();
    #1 expect_out("lh_m0", 4'b0001, 1'b1, 1'b1, 4'b0001, pat(0, 3), 2'd0);
    cyc();

    // backpressure
    do_reset();
    m_valid = 4'b0100; m_last = '0; s_ready = 1'b0; setdata(0);
    #1 expect_idle("bp_arb");
    cyc();
    rdys = '{1'b0, 1'b1, 1'b0, 1'b1};
    beat = 0;
    for (int c = 0; c < 4; c++) begin
      s_ready = rdys[c];
      m_last = (beat == 1) ? 4'b0100 : 4'b0000;
      setdata(beat);
      #1 expect_out($sformatf("bp_c%0d", c), 4'b0100, 1'b1, beat == 1,
                    rdys[c] ? 4'b0100 : 4'b0000, pat(2, beat), 2'd2);
      if (rdys[c]) beat++;
      cyc();
    end
    m_valid = '0; m_last = '0;
    #1 expect_idle("bp_done");
    cyc();

    // wrap-around
    do_reset();
    m_valid = 4'b1000; m_last = 4'b1000; s_ready = 1'b1; setdata(0);
    #1 expect_idle("wr_arb");
    cyc();
    #1 expect_out("wr_m3", 4'b1000, 1'b1, 1'b1, 4'b1000, pat(3, 0), 2'd3);
    cyc();
    m_valid = 4'b1001; m_last = 4'b1001;
    #1 expect_idle("wr_bubble");
    cyc();
    #1 expect_out("wr_m0", 4'b0001, 1'b1, 1'b1, 4'b0001, pat(0, 0), 2'd0);
    cyc();

    // reset mid-burst
    do_reset();
    m_valid = 4'b0010; m_last = '0; s_ready = 1'b1; setdata(0);
    #1 expect_idle("rm_arb");
    cyc();
    #1 expect_out("rm_b0", 4'b0010, 1'b1, 1'b0, 4'b0010, pat(1, 0), 2'd1);
    cyc();
    rst_n = 1'b0; setdata(1);
    #1 chk("rm_noack", 64'(m_ready), 64'(0));
    cyc();
    rst_n = 1'b1;
    #1 expect_idle("rm_after");
    cyc();
    #1 expect_out("rm_regrant", 4'b0010, 1'b1, 1'b0, 4'b0010,
                  pat(1, 1), 2'd1);
    cyc();

    // randomized against the reference model
    do_reset();
    mlock = 1'b0; mown = 0; mprio = 0;
    for (int t = 0; t < 3000; t++) begin
      m_valid = 4'($urandom);
      m_last  = 4'($urandom) & 4'($urandom);
      s_ready = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) m_data[k*DW +: DW] = $urandom;
      #1;
      eg = 0; esv = 0; esl = 0; emr = 0; esd = 0;
      if (mlock) begin
        eg  = 4'(1 << mown);
        esv = m_valid[mown];
        esl = esv & m_last[mown];
        emr = s_ready ? eg : 4'b0;
        esd = esv ? m_data[mown*DW +: DW] : '0;
      end
      expect_out($sformatf("rnd%0d", t), eg, esv, esl, emr, esd, 2'(mown));
      if (mlock) begin
        if (esv && s_ready && m_last[mown]) begin
          mlock = 1'b0;
          mprio = (mown + 1) % N;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!mlock && m_valid[(mprio + i) % N]) begin
            mlock = 1'b1;
            mown = (mprio + i) % N;
          end
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
